// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the multi-stage reset release sequencer.
package rst_seq_pkg;

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_UP    = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  typedef enum logic [1:0] {
    HOLD  = ST_HOLD,
    WAIT  = ST_WAIT,
    UP    = ST_UP,
    FAULT = ST_FAULT
  } state_e;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_tmr.sv
// Clearable up-counter with an exact compare-to-limit done flag.
module rst_seq_tmr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] lim_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear dominates; the owner stops enabling once done so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == lim_i);

endmodule

// File: rtl/rst_seq.sv
// Releases NUM_STG reset domains in order, waiting for each stage's ready and
// latching a fault with the stage index if a stage times out.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STG  = 3,
  parameter int HOLD_CYC = 4,
  parameter int TMO_CYC  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sw_rst_req,
  input  logic [NUM_STG-1:0]         stg_rdy,
  output logic [NUM_STG-1:0]         stg_rst_n,
  output logic                       all_up,
  output logic                       fault,
  output logic [$clog2(NUM_STG)-1:0] fault_stg
);

  localparam int IDX_W = $clog2(NUM_STG);
  // Floor of 1 keeps the counter legal when both limits are 1.
  localparam int CNT_W = max(1, $clog2(max(HOLD_CYC, TMO_CYC)));
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TMO_CYC - 1);

  if (NUM_STG < 2 || NUM_STG > 8) begin : g_bad_num_stg
    $error("rst_seq: NUM_STG must be in 2..8");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold_cyc
    $error("rst_seq: HOLD_CYC must be >= 1");
  end
  if (TMO_CYC < 1) begin : g_bad_tmo_cyc
    $error("rst_seq: TMO_CYC must be >= 1");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_STG-1:0] stg_rst_n_q, stg_rst_n_d;
  logic               all_up_q, all_up_d;
  logic               fault_q, fault_d;
  logic [IDX_W-1:0]   fault_stg_q, fault_stg_d;

  logic               tmr_clr;
  logic               tmr_en;
  logic               tmr_done;
  logic [CNT_W-1:0]   tmr_lim;

  assign tmr_lim = (state_q == HOLD) ? HOLD_LIM : TMO_LIM;

  rst_seq_tmr #(
    .W(CNT_W)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .lim_i  (tmr_lim),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stg_rst_n_d = stg_rst_n_q;
    all_up_d    = all_up_q;
    fault_d     = fault_q;
    fault_stg_d = fault_stg_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    // Soft reset outranks ready and timeout; holding it keeps the counter at 0.
    if (sw_rst_req) begin
      state_d     = HOLD;
      idx_d       = '0;
      stg_rst_n_d = '0;
      all_up_d    = 1'b0;
      fault_d     = 1'b0;
      fault_stg_d = '0;
      tmr_clr     = 1'b1;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (tmr_done) begin
            stg_rst_n_d[0] = 1'b1;
            idx_d          = '0;
            tmr_clr        = 1'b1;
            state_d        = WAIT;
          end else begin
            tmr_en = 1'b1;
          end
        end
        WAIT: begin
          if (stg_rdy[idx_q]) begin
            tmr_clr = 1'b1;
            if (idx_q < IDX_W'(NUM_STG - 1)) begin
              for (int i = 1; i < NUM_STG; i++) begin
                if (idx_q == IDX_W'(i - 1)) begin
                  stg_rst_n_d[i] = 1'b1;
                end
              end
              idx_d = idx_q + IDX_W'(1);
            end else begin
              all_up_d = 1'b1;
              state_d  = UP;
            end
          end else if (tmr_done) begin
            // Only the stalled stage goes back into reset; earlier stages stay up.
            fault_d              = 1'b1;
            fault_stg_d          = idx_q;
            stg_rst_n_d[idx_q]   = 1'b0;
            state_d              = FAULT;
          end else begin
            tmr_en = 1'b1;
          end
        end
        UP:      ;
        FAULT:   ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      idx_q       <= '0;
      stg_rst_n_q <= '0;
      all_up_q    <= 1'b0;
      fault_q     <= 1'b0;
      fault_stg_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stg_rst_n_q <= stg_rst_n_d;
      all_up_q    <= all_up_d;
      fault_q     <= fault_d;
      fault_stg_q <= fault_stg_d;
    end
  end

  assign stg_rst_n = stg_rst_n_q;
  assign all_up    = all_up_q;
  assign fault     = fault_q;
  assign fault_stg = fault_stg_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with NUM_STG=3, HOLD_CYC=4, TMO_CYC=8.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] stg_rdy = 3'b000;
  logic [2:0] stg_rst_n;
  logic       all_up;
  logic       fault;
  logic [1:0] fault_stg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sw;
    logic [2:0] rdy;
    logic [2:0] e_rst;
    logic       e_up;
    logic       e_f;
    logic [1:0] e_fs;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  rst_seq #(
    .NUM_STG  (3),
    .HOLD_CYC (4),
    .TMO_CYC  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req),
    .stg_rdy    (stg_rdy),
    .stg_rst_n  (stg_rst_n),
    .all_up     (all_up),
    .fault      (fault),
    .fault_stg  (fault_stg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [2:0] e_rst, input logic e_up,
                       input logic e_f, input logic [1:0] e_fs);
    checks++;
    if ({stg_rst_n, all_up, fault, fault_stg} !== {e_rst, e_up, e_f, e_fs}) begin
      errors++;
      $display("FAIL %s: got rst_n=%b up=%b fault=%b stg=%0d, want rst_n=%b up=%b fault=%b stg=%0d",
               name, stg_rst_n, all_up, fault, fault_stg, e_rst, e_up, e_f, e_fs);
    end else begin
      $display("ok   %s: rst_n=%b up=%b fault=%b stg=%0d", name, stg_rst_n, all_up, fault, fault_stg);
    end
  endtask

  // Drive inputs, take one edge, sample 1ns later.
  task automatic step(input logic sw, input logic [2:0] rdy, input logic [2:0] e_rst,
                      input logic e_up, input logic e_f, input logic [1:0] e_fs, input string name);
    sw_rst_req = sw;
    stg_rdy    = rdy;
    @(posedge clk);
    #1;
    check(name, e_rst, e_up, e_f, e_fs);
  endtask

  // Assert rst_n between edges, then release it so the next posedge is edge 1.
  task automatic pulse_reset(input string name);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(name, 3'b000, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #3;
    sw_rst_req = 1'b0;
    rst_n = 1'b1;
  endtask

  // Expected outputs of a clean run with all stages ready, edge e after release.
  task automatic clean_edge(input int e, input string tag);
    logic [2:0] er;
    logic       eu;
    er = (e < 4) ? 3'b000 : (e == 4) ? 3'b001 : (e == 5) ? 3'b011 : 3'b111;
    eu = (e >= 7);
    step(1'b0, 3'b111, er, eu, 1'b0, 2'd0, $sformatf("%s e%0d", tag, e));
  endtask

  initial begin
    // Straight run, soft reset held two cycles, then a slow stage 1 with don't-care bits.
    vecs[0]  = '{1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 3'b111, 3'b001, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 3'b111, 3'b011, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{1'b0, 3'b000, 3'b111, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0};
    vecs[9]  = '{1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0};
    vecs[14] = '{1'b0, 3'b001, 3'b011, 1'b0, 1'b0, 2'd0};
    vecs[15] = '{1'b0, 3'b001, 3'b011, 1'b0, 1'b0, 2'd0};
    vecs[16] = '{1'b0, 3'b001, 3'b011, 1'b0, 1'b0, 2'd0};
    vecs[17] = '{1'b0, 3'b010, 3'b111, 1'b0, 1'b0, 2'd0};
    vecs[18] = '{1'b0, 3'b100, 3'b111, 1'b1, 1'b0, 2'd0};
    vecs[19] = '{1'b0, 3'b000, 3'b111, 1'b1, 1'b0, 2'd0};

    #1;
    check("reset t0", 3'b000, 1'b0, 1'b0, 2'd0);
    stg_rdy = 3'b111;
    @(posedge clk);
    #1;
    check("reset held with rdy", 3'b000, 1'b0, 1'b0, 2'd0);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].sw, vecs[i].rdy, vecs[i].e_rst, vecs[i].e_up, vecs[i].e_f,
           vecs[i].e_fs, $sformatf("table row %0d", i));
    end

    // Timeout on stage 1: released at edge 5, fault at edge 13.
    pulse_reset("async reset before timeout");
    for (int e = 1; e <= 13; e++) begin
      logic [2:0] er;
      er = (e < 4) ? 3'b000 : (e == 4) ? 3'b001 : (e < 13) ? 3'b011 : 3'b001;
      step(1'b0, 3'b001, er, 1'b0, (e == 13), (e == 13) ? 2'd1 : 2'd0,
           $sformatf("timeout e%0d", e));
    end
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 3'b111, 3'b001, 1'b0, 1'b1, 2'd1, $sformatf("fault frozen c%0d", c));
    end

    // Recovery via one-cycle soft reset.
    step(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, "recovery sw pulse");
    for (int e = 1; e <= 8; e++) clean_edge(e, "recovery");

    // Soft reset collides with the first ready sample of stage 0.
    step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0, "collision pre sw");
    for (int e = 1; e <= 3; e++) begin
      step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0, $sformatf("collision hold e%0d", e));
    end
    step(1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, "collision stage0 up");
    step(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 2'd0, "collision sw beats rdy");
    for (int e = 1; e <= 5; e++) clean_edge(e, "collision restart");

    // Async reset while waiting on stage 1.
    pulse_reset("async reset before midwait");
    for (int e = 1; e <= 5; e++) begin
      logic [2:0] er;
      er = (e < 4) ? 3'b000 : (e == 4) ? 3'b001 : 3'b011;
      step(1'b0, 3'b001, er, 1'b0, 1'b0, 2'd0, $sformatf("midwait e%0d", e));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midwait async clear", 3'b000, 1'b0, 1'b0, 2'd0);
    #2;
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) clean_edge(e, "midwait restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
